// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
package keypad_pkg;

  // Number of flops between the raw row pins and the scanner's decision logic.
  localparam int SYNC_STAGES = 2;

  // Scanner state. The ST_ prefix keeps the literals distinct from the
  // DEBOUNCE parameter of the scanner.
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Hex legend of the standard 4x4 keypad:
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E 0 F D
  function automatic logic [3:0] hex_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Multi-flop synchroniser for the asynchronous, active-low row returns.
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [SYNC_STAGES];

  // Shift the pins through the chain; reset loads the idle (pulled-up) level
  // so no phantom press is seen right after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '1;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: rotates the active column, debounces press and
// release of the first key found, and reports one registered code per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 2,
  parameter int DEBOUNCE = 20000,
  parameter int MAP_HEX  = 1,
  parameter int KW       = (MAP_HEX != 0) ? 4 :
                           (($clog2(ROWS*COLS) > 1) ? $clog2(ROWS*COLS) : 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] rows_n,
  output logic [COLS-1:0] cols_n,
  output logic [KW-1:0]   key,
  output logic            key_valid,
  output logic            key_held
);

  localparam int CMAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int CIW  = $clog2(COLS);
  localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0]  SETTLE_CNT = CW'(SETTLE);
  localparam logic [CW-1:0]  DEB_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]  CNT_SAT    = CW'(CMAX);
  localparam logic [CIW-1:0] COL_LAST   = CIW'(COLS - 1);

  // The hex legend only exists for the 4x4 layout.
  if (MAP_HEX != 0 && (ROWS != 4 || COLS != 4)) begin : g_bad_map
    $error("keypad_scanner: MAP_HEX=1 needs ROWS=4 and COLS=4");
  end

  // Counter increment that sticks at its ceiling instead of wrapping.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
    return (v == CNT_SAT) ? v : v + CW'(1);
  endfunction

  // Next column in the rotation, wrapping at COLS-1 (COLS need not be 2^n).
  function automatic logic [CIW-1:0] col_next(input logic [CIW-1:0] v);
    return (v == COL_LAST) ? '0 : v + CIW'(1);
  endfunction

  // Key code for row r, column c in the selected mapping mode.
  function automatic logic [KW-1:0] key_code(input logic [RIW-1:0] r,
                                             input logic [CIW-1:0] c);
    if (MAP_HEX != 0) return KW'(hex_map(2'(r), 2'(c)));
    else              return KW'(int'(r) * COLS + int'(c));
  endfunction

  logic [ROWS-1:0] rs;
  logic            low_any;
  logic [RIW-1:0]  low_row;

  state_t         state_q, state_d;
  logic [CIW-1:0] col_q, col_d;
  logic [RIW-1:0] row_q, row_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  key_q, key_d;
  logic           valid_q, valid_d;
  logic           held_q, held_d;

  keypad_sync #(.W(ROWS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows_n),
    .q     (rs)
  );

  // Priority pick of the lowest-index asserted row.
  always_comb begin
    low_any = ~&rs;
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs[i]) low_row = RIW'(i);
    end
  end

  // Next-state, counters, column rotation and output updates.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q != SETTLE_CNT) begin
          cnt_d = cnt_inc(cnt_q);
        end else begin
          cnt_d = '0;
          if (low_any) begin
            row_d   = low_row;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_next(col_q);
          end
        end
      end
      ST_DEBOUNCE: begin
        if (rs[row_q]) begin
          cnt_d   = '0;
          col_d   = col_next(col_q);
          state_d = ST_SCAN;
        end else if (cnt_q == DEB_LAST) begin
          key_d   = key_code(row_q, col_q);
          valid_d = 1'b1;
          held_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      ST_HELD: begin
        if (rs[row_q]) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!rs[row_q]) begin
          state_d = ST_HELD;
        end else if (cnt_q == DEB_LAST) begin
          held_d  = 1'b0;
          cnt_d   = '0;
          col_d   = col_next(col_q);
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SCAN;
      end
    endcase
  end

  // State register; reset abandons any press in progress without a pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign cols_n    = ~(COLS'(1) << col_q);
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner and debouncer. It drives keypad columns one at a time, synchronises and debounces the row returns, and reports one registered key code per press. It sits between the board keypad pins and the 7-segment display path, and replaces the fixed 4x4 decoder. Geometry, debounce length and the hex-mapping mode are set by parameters.

## Interface
- `ROWS`, default 4: number of keypad rows (≥1).
- `COLS`, default 4: number of keypad columns (≥2).
- `SETTLE`, default 2: cycles a column is driven before its rows are sampled (≥1).
- `DEBOUNCE`, default 20000: consecutive stable samples required for press and for release (≥1).
- `MAP_HEX`, default 1: 1 gives a hex-legend code (only legal with 4x4); 0 gives the raw index.
- `KW`, derived: 4 if `MAP_HEX`, else max(1, $clog2(ROWS*COLS)).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `rows_n`  in  ROWS  asynchronous row returns, active-low (pulled up).
- `cols_n`  out  COLS  column drive, active-low, exactly one bit low at all times.
- `key`  out  KW  code of the last accepted key; held until the next acceptance.
- `key_valid`  out  1  one-cycle pulse when `key` updates.
- `key_held`  out  1  high from acceptance until the debounced release.

## Operation
- `rows_n` passes through a 2-flop synchroniser. All decisions use the synchronised value `rs`.
- **Reset** (`reset`=0 at a clk edge) sets:
  - `cols_n` = ~1 (column 0 active), column index 0, settle and debounce counters 0;
  - state SCAN;
  - `key`=0, `key_valid`=0, `key_held`=0.
- Reset mid-press abandons the press with no pulse.
- **SCAN**:
  - Drive column c. Count `SETTLE` cycles, then sample `rs`.
  - If any bit is low, capture the lowest-index low row as r, hold column c, clear the counter, go to DEBOUNCE.
  - Otherwise c ← (c+1) mod COLS, clear the settle counter, stay in SCAN.
- **DEBOUNCE**:
  - Each cycle `rs[r]`=0 increments the counter. When the count reaches `DEBOUNCE`: latch `key`, pulse `key_valid`, set `key_held`, go to HELD.
  - Any cycle with `rs[r]`=1 returns to SCAN with the column advanced. No pulse.
- **HELD**: column stays fixed. When `rs[r]`=1, clear the counter and go to RELEASE.
- **RELEASE**:
  - Each cycle `rs[r]`=1 increments the counter. At `DEBOUNCE`: clear `key_held`, go to SCAN with the column advanced.
  - Any cycle with `rs[r]`=0 returns to HELD with no new pulse.
- **No rollover**: other rows, and other columns (not driven), are ignored from DEBOUNCE through RELEASE. A second key still down after release is found by the normal scan and reported as a new press.
- **Code**:
  - `MAP_HEX`=0: `key` = r*COLS + c.
  - `MAP_HEX`=1: `key` = `hex_map(r,c)`, layout row0 `1 2 3 A`, row1 `4 5 6 B`, row2 `7 8 9 C`, row3 `E 0 F D`.
- Counters are sized $clog2(max(SETTLE,DEBOUNCE)+1) and saturate; they never wrap.

## Timing
- Sync latency: 2 cycles from pin to `rs`.
- Scan period: (SETTLE+1)·COLS cycles per full sweep when idle.
- Press latency:
  - Let E be the edge at which SCAN samples `rs[r]`=0.
  - `key_valid` is high for exactly the cycle after edge E+DEBOUNCE.
  - `key` and `key_held` update on that same edge.
- `key_held` falls DEBOUNCE cycles after the first high sample of `rs[r]` in HELD.
- Simultaneous events:
  - Two rows low at the sample: the lower row wins.
  - Reset overrides all transitions.

## Structure
- Package `keypad_pkg` holds:
  - the `state_t` enum {SCAN, DEBOUNCE, HELD, RELEASE};
  - the `hex_map` function / 4x4 constant array;
  - the `SYNC_STAGES`=2 constant.
- Sub-module `keypad_sync` is the parametrised-width 2-flop synchroniser.
- The FSM, counters and column rotation live in `keypad_scanner`.
- An elaboration-time check rejects `MAP_HEX`=1 unless ROWS=COLS=4.

## Test plan
The bench keypad model is `rows_n[r] = ~|(pressed[r][*] & ~cols_n)`. Simulation uses DEBOUNCE=4, SETTLE=2.
- Reset: after 3 cycles of `reset`=0 → `cols_n`=4'b1110, `key`=0, `key_valid`=0, `key_held`=0.
- Press (1,2) for 40 cycles, then release → exactly one `key_valid` pulse; `key`=4'h6; `key_held` stays high until 4 cycles after the synchronised release.
- Bounce: press (0,0) for 2 cycles only → no `key_valid`; scanning resumes and `cols_n` keeps rotating.
- Rollover: hold (0,0), then add (1,1), then release (0,0) while holding (1,1) → pulse with `key`=4'h1, then after release debounce and scan a second pulse with `key`=4'h5.
- Release glitch: while (3,1) is held, the row goes high for 2 cycles → `key_held` stays 1 and no extra pulse; `key`=4'h0.
- Mode and reset: with ROWS=3, COLS=5, MAP_HEX=0, press (2,4) → `key`=14. A second press with `reset` asserted mid-DEBOUNCE → no pulse, and all outputs return to reset values.
